// File: rtl/rvm_mem_arbiter.sv
// Memory port arbiter: shares one memory port between fetch (f_*) and load/store (d_*) requesters.
// Optional round-robin arbitration when RVM_MEM_ARB_RR_EN is defined; otherwise data has fixed priority.
//
// state | meaning
// IDLE  | no access in flight; sample requests and latch the winner
// ACC   | drive the memory port until the memory accepts or the stall timer expires
// RESP  | present a one-cycle done pulse to the winner, then return to IDLE
module rvm_mem_arbiter #(
  parameter int STALL_TIMEOUT = 255,
  parameter int TMO_W         = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  output logic        f_error,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_ben,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_error,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic        mem_c_en,
  output logic [3:0]  mem_b_en,
  output logic        mem_w_en,
  input  logic        mem_error,
  input  logic        mem_stall,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(STALL_TIMEOUT);
  localparam bit               TMO_ON    = (STALL_TIMEOUT != 0);

  state_t            state_q, state_nxt;
  logic [TMO_W-1:0]  cnt_q, cnt_nxt, cnt_inc;
  logic              sel_d_q, sel_d_nxt;
  logic              grant_any, grant_d;
  logic              timeout_hit;

  logic              f_done_nxt, f_error_nxt, d_done_nxt, d_error_nxt;
  logic [31:0]       f_rdata_nxt, d_rdata_nxt;
  logic [31:0]       mem_addr_nxt, mem_wdata_nxt;
  logic              mem_c_en_nxt, mem_w_en_nxt;
  logic [3:0]        mem_b_en_nxt;
  logic              busy_nxt;

`ifdef RVM_MEM_ARB_RR_EN
  // last_d_q = 1 when data won most recently; a tie goes to the other side.
  logic last_d_q, last_d_nxt;
  assign grant_d = d_req & (~f_req | ~last_d_q);
`else
  assign grant_d = d_req;
`endif

  assign grant_any   = d_req | f_req;
  assign cnt_inc     = cnt_q + TMO_W'(1);
  assign timeout_hit = TMO_ON && (cnt_inc == TMO_LIMIT);

  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    sel_d_nxt     = sel_d_q;
    f_done_nxt    = 1'b0;
    f_rdata_nxt   = '0;
    f_error_nxt   = 1'b0;
    d_done_nxt    = 1'b0;
    d_rdata_nxt   = '0;
    d_error_nxt   = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_c_en_nxt  = mem_c_en;
    mem_b_en_nxt  = mem_b_en;
    mem_w_en_nxt  = mem_w_en;
`ifdef RVM_MEM_ARB_RR_EN
    last_d_nxt    = last_d_q;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_nxt = '0;
        if (grant_any) begin
          state_nxt     = ACC;
          sel_d_nxt     = grant_d;
          mem_c_en_nxt  = 1'b1;
          mem_addr_nxt  = grant_d ? d_addr : f_addr;
          mem_wdata_nxt = grant_d ? d_wdata : 32'h0;
          mem_b_en_nxt  = grant_d ? d_ben : 4'hF;
          mem_w_en_nxt  = grant_d & d_wen;
`ifdef RVM_MEM_ARB_RR_EN
          last_d_nxt    = grant_d;
`endif
        end
      end

      ACC: begin
        if (!mem_stall || timeout_hit) begin
          state_nxt     = RESP;
          cnt_nxt       = '0;
          mem_c_en_nxt  = 1'b0;
          mem_addr_nxt  = '0;
          mem_wdata_nxt = '0;
          mem_b_en_nxt  = '0;
          mem_w_en_nxt  = 1'b0;
          // A completed access wins over a timeout that lands on the same cycle.
          if (!mem_stall) begin
            d_done_nxt  = sel_d_q;
            f_done_nxt  = ~sel_d_q;
            d_rdata_nxt = (sel_d_q && !mem_w_en) ? mem_rdata : 32'h0;
            f_rdata_nxt = sel_d_q ? 32'h0 : mem_rdata;
            d_error_nxt = sel_d_q & mem_error;
            f_error_nxt = ~sel_d_q & mem_error;
          end else begin
            d_done_nxt  = sel_d_q;
            f_done_nxt  = ~sel_d_q;
            d_error_nxt = sel_d_q;
            f_error_nxt = ~sel_d_q;
          end
        end else begin
          cnt_nxt = (cnt_q == '1) ? cnt_q : cnt_inc;
        end
      end

      RESP: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_d_q   <= 1'b0;
      f_done    <= 1'b0;
      f_rdata   <= '0;
      f_error   <= 1'b0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      d_error   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_c_en  <= 1'b0;
      mem_b_en  <= '0;
      mem_w_en  <= 1'b0;
      busy      <= 1'b0;
`ifdef RVM_MEM_ARB_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      sel_d_q   <= sel_d_nxt;
      f_done    <= f_done_nxt;
      f_rdata   <= f_rdata_nxt;
      f_error   <= f_error_nxt;
      d_done    <= d_done_nxt;
      d_rdata   <= d_rdata_nxt;
      d_error   <= d_error_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_c_en  <= mem_c_en_nxt;
      mem_b_en  <= mem_b_en_nxt;
      mem_w_en  <= mem_w_en_nxt;
      busy      <= busy_nxt;
`ifdef RVM_MEM_ARB_RR_EN
      last_d_q  <= last_d_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Scoreboard bench for rvm_mem_arbiter: stimulus queues expected done pulses, a negedge monitor checks them.
module tb_rvm_mem_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        f_req, d_req, d_wen;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic [3:0]  d_ben;
  logic        f_done, f_error, d_done, d_error;
  logic [31:0] f_rdata, d_rdata;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_c_en, mem_w_en, mem_error, mem_stall, busy;
  logic [3:0]  mem_b_en;

  rvm_mem_arbiter #(.STALL_TIMEOUT(TMO), .TMO_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_error(f_error),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_ben(d_ben),
    .d_done(d_done), .d_rdata(d_rdata), .d_error(d_error),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_c_en(mem_c_en),
    .mem_b_en(mem_b_en), .mem_w_en(mem_w_en), .mem_error(mem_error), .mem_stall(mem_stall),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_left = 0;
  bit   err_stall = 1'b0;
  bit   err_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory model: stalls for stall_left cycles of an enabled access, error per phase.
  always @(negedge clk) begin
    if (mem_c_en && stall_left > 0) begin
      mem_stall = 1'b1;
      mem_error = err_stall;
      stall_left--;
    end else begin
      mem_stall = 1'b0;
      mem_error = err_done;
    end
  end

  always @(negedge clk) begin
    if (f_done || d_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {f_done, d_done}, 0);
      end else begin
        mon_e = q.pop_front();
        chk("done_side", {f_done, d_done}, mon_e.is_d ? 2'b01 : 2'b10);
        chk("done_rdata", mon_e.is_d ? d_rdata : f_rdata, mon_e.rdata);
        chk("done_error", mon_e.is_d ? d_error : f_error, mon_e.err);
        chk("done_cycle", cyc, mon_e.cyc);
        chk("loser_zero", mon_e.is_d ? {f_rdata, f_error} : {d_rdata, d_error}, 0);
      end
    end
  end

  task automatic push_exp(input bit is_d, input logic [31:0] rd, input bit err, input int at);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rd;
    e.err   = err;
    e.cyc   = at;
    q.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_resp"}, {f_done, f_rdata, f_error, d_done, d_rdata, d_error}, 0);
    chk({name, "_mem"}, {mem_addr, mem_wdata, mem_c_en, mem_b_en, mem_w_en, busy}, 0);
  endtask

  task automatic access(input bit is_d, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] ben, input int stalls,
                        input logic [31:0] rd, input bit es, input bit ed,
                        input logic [31:0] exp_rd, input bit exp_err, input int lat);
    bit seen;
    stall_left = stalls;
    mem_rdata  = rd;
    err_stall  = es;
    err_done   = ed;
    push_exp(is_d, exp_rd, exp_err, cyc + lat);
    if (is_d) begin
      d_req = 1'b1; d_wen = wen; d_addr = addr; d_wdata = wdata; d_ben = ben;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    @(negedge clk);
    chk("acc_c_en", mem_c_en, 1);
    chk("acc_addr", mem_addr, addr);
    chk("acc_w_en", mem_w_en, is_d ? wen : 1'b0);
    chk("acc_b_en", mem_b_en, is_d ? ben : 4'hF);
    chk("acc_wdata", mem_wdata, is_d ? wdata : 32'h0);
    chk("acc_busy", busy, 1);
    if (stalls > 0) begin
      d_addr = ~addr; f_addr = ~addr; d_wdata = ~wdata; d_ben = ~ben;
      @(negedge clk);
      chk("latched_fields", {mem_addr, mem_wdata, mem_b_en},
          {addr, is_d ? wdata : 32'h0, is_d ? ben : 4'hF});
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (f_done || d_done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", seen, 1);
    f_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk("idle_after", {busy, mem_c_en, f_done, d_done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    resetn = 1'b0;
    f_req = 0; d_req = 0; d_wen = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0; d_ben = 0;
    mem_rdata = 0; mem_error = 0; mem_stall = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);

    // fetch, no stall
    access(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'h0000_0013, 1'b0, 1'b0, 32'h13, 1'b0, 2);
    // store, three stall cycles: rdata forced to zero
    access(1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3, 3, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0, 5);
    // fetch completing with mem_error, then a clean load
    access(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 2);
    access(1'b1, 1'b0, 32'h2004, 32'h1111_2222, 4'hC, 0, 32'h0BAD_C0DE, 1'b0, 1'b0, 32'h0BAD_C0DE, 1'b0, 2);
    // mem_error only while stalled is ignored
    access(1'b1, 1'b0, 32'h2008, 32'h0, 4'hF, 2, 32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 4);
    // timeout after TMO stall cycles
    access(1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1000, 32'hAAAA_5555, 1'b0, 1'b0, 32'h0, 1'b1, TMO + 1);
    stall_left = 0;
    // fetch timeout
    access(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 1000, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0, 1'b1, TMO + 1);
    stall_left = 0;

    // reset in the middle of an access: no done for the dropped access
    stall_left = 10;
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h4000; d_wdata = 32'h5A5A_5A5A; d_ben = 4'hF;
    @(negedge clk);
    chk("pre_reset_c_en", mem_c_en, 1);
    resetn = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    @(negedge clk);
    check_all_zero("mid_reset_hold");
    resetn = 1'b1;
    stall_left = 0;
    @(negedge clk);
    chk("post_reset_busy", {busy, f_done, d_done}, 0);

    // tie with both requests held across four accesses
    mem_rdata = 32'h0000_0055;
    err_done = 1'b0;
    err_stall = 1'b0;
    t = cyc;
`ifdef RVM_MEM_ARB_RR_EN
    push_exp(1'b1, 32'h55, 1'b0, t + 2);
    push_exp(1'b0, 32'h55, 1'b0, t + 5);
    push_exp(1'b1, 32'h55, 1'b0, t + 8);
    push_exp(1'b0, 32'h55, 1'b0, t + 11);
`else
    push_exp(1'b1, 32'h55, 1'b0, t + 2);
    push_exp(1'b1, 32'h55, 1'b0, t + 5);
    push_exp(1'b1, 32'h55, 1'b0, t + 8);
    push_exp(1'b1, 32'h55, 1'b0, t + 11);
`endif
    f_req = 1'b1; f_addr = 32'h300;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h5000; d_ben = 4'hF;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (f_done || d_done) n++;
    end
    f_req = 1'b0;
    d_req = 1'b0;
    chk("tie_count", n, 4);
    repeat (3) @(negedge clk);
    chk("idle_end", {busy, mem_c_en}, 0);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
